// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   WIDTH            - default data/address width
//   DEFAULT_LATENCY  - default number of WAIT cycles per access
//   dmem_state_t     - FSM state encoding (2 bits)
package dmem_responder_pkg;

    localparam int WIDTH           = 32;
    localparam int DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read.
// Contents are never reset; the read register only updates on a read.
//   clk   - clock
//   en    - access enable (one cycle per access)
//   we    - 1 = write wdata to mem[idx], 0 = register mem[idx] into rdata
//   idx   - word index
//   wdata - write data
//   rdata - registered read data, holds until the next read
module dmem_array #(
    parameter int WIDTH = dmem_responder_pkg::WIDTH,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[idx] <= wdata;
            else    rdata    <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage load/store port.
// Accepts one word-aligned request at a time, waits LATENCY cycles, then
// pulses resp_valid for one cycle. Stalls the pipeline while busy.
//   clk        - clock
//   rst        - asynchronous active-low reset
//   req_valid  - request present (held stable by the core while stalled)
//   req_write  - 1 = store, 0 = load
//   req_addr   - byte address
//   req_wdata  - store data
//   stall_mem  - combinational stall toward the hazard unit
//   resp_valid - one-cycle completion pulse
//   resp_rdata - load data; 0 for stores and errors
//   resp_err   - misaligned / out-of-range access, qualified by resp_valid
module dmem_responder #(
    parameter int WIDTH       = dmem_responder_pkg::WIDTH,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = dmem_responder_pkg::DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             stall_mem,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    import dmem_responder_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] wdata_q;
    logic             rd_sel_q;   // last completed access was a good load
    logic [WIDTH-1:0] arr_rdata;
    logic [IDX_W-1:0] req_idx;
    logic             req_bad;
    logic             access;

    // Any address bit above the word index makes the access out of range;
    // the index compare covers non-power-of-two depths.
    assign req_idx = req_addr[IDX_W+1:2];
    assign req_bad = (req_addr[1:0] != 2'b00)
                   || ((req_addr >> (IDX_W + 2)) != '0)
                   || (int'(req_idx) >= DEPTH_WORDS);

    assign access     = (state_q == DMEM_WAIT) && (cnt_q == '0);
    assign stall_mem  = req_valid && (state_q != DMEM_RESP);
    assign resp_valid = (state_q == DMEM_RESP);
    // The array read register only moves on loads, so stores and errors
    // mask it off rather than clearing storage-side state.
    assign resp_rdata = rd_sel_q ? arr_rdata : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DMEM_IDLE: if (req_valid) state_d = req_bad ? DMEM_RESP : DMEM_WAIT;
            DMEM_WAIT: if (cnt_q == '0) state_d = DMEM_RESP;
            DMEM_RESP: state_d = DMEM_IDLE;
            default:   state_d = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DMEM_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rd_sel_q <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DMEM_IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        idx_q   <= req_idx;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_W'(LATENCY - 1);
                        // Error completes on this edge; good accesses keep
                        // the previous response until their own completion.
                        if (req_bad) begin
                            resp_err <= 1'b1;
                            rd_sel_q <= 1'b0;
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        resp_err <= 1'b0;
                        rd_sel_q <= ~wr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    dmem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (access),
        .we    (wr_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall_mem, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_stall_mem, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(LAT_A)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_mem(stall_mem), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .stall_mem(b_stall_mem), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the LATENCY=2 instance starting now (just after a
    // rising edge), check stall/valid every cycle, the response, and that
    // the response fields hold in the following idle cycle.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_err,
                             input logic [31:0] exp_rdata);
        int rc;
        rc = exp_err ? 1 : LAT_A + 1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int c = 0; c <= rc; c++) begin
            @(negedge clk);
            chk({tag, " stall"}, 32'(stall_mem), 32'(c < rc));
            chk({tag, " valid"}, 32'(resp_valid), 32'(c == rc));
            if (c == rc) begin
                chk({tag, " rdata"}, resp_rdata, exp_rdata);
                chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk({tag, " idle valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " idle stall"}, 32'(stall_mem), 32'd0);
        chk({tag, " hold rdata"}, resp_rdata, exp_rdata);
        chk({tag, " hold err"}, 32'(resp_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [0:5] b_st;
        logic [0:5] b_vl;
        b_st = 6'b110110;
        b_vl = 6'b001001;

        // Reset values; stall follows req_valid even in reset
        #1 rst = 1'b0;
        #1;
        chk("rst valid", 32'(resp_valid), 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", 32'(resp_err), 32'd0);
        chk("rst stall", 32'(stall_mem), 32'd0);
        req_valid = 1'b1;
        #1;
        chk("rst stall follows req", 32'(stall_mem), 32'd1);
        req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Store then load
        do_access("st 10", 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        do_access("ld 10", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Misaligned load, then the word is untouched
        do_access("ld 13", 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
        do_access("ld 10 again", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Out of range store aliases word 0 if the range check is missing
        do_access("st 0", 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h0);
        do_access("st 400", 1'b1, 32'h400, 32'hCAFEF00D, 1'b1, 32'h0);
        do_access("ld 0", 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111);

        // Flush during WAIT: store still commits, response still pulses
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(negedge clk);
        chk("flush c0 stall", 32'(stall_mem), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("flush c1 stall", 32'(stall_mem), 32'd0);
        chk("flush c1 valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush c2 valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("flush c3 valid", 32'(resp_valid), 32'd1);
        chk("flush c3 err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_access("st 30", 1'b1, 32'h30, 32'h1, 1'b0, 32'h0);
        do_access("ld 20", 1'b0, 32'h20, 32'h0, 1'b0, 32'h12345678);

        // Reset in the last WAIT cycle of a store: dropped, outputs clear
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAA5555;
        @(negedge clk);
        chk("rstmid c0 stall", 32'(stall_mem), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid c1 stall", 32'(stall_mem), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid rdata clr", resp_rdata, 32'd0);
        chk("rstmid err clr", 32'(resp_err), 32'd0);
        chk("rstmid valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid c3 valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post rst valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        do_access("ld 30", 1'b0, 32'h30, 32'h0, 1'b0, 32'h1);

        // LATENCY=1, two requests held back to back
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h5A5A5A5A;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("l1 c%0d stall", c), 32'(b_stall_mem), 32'(b_st[c]));
            chk($sformatf("l1 c%0d valid", c), 32'(b_resp_valid), 32'(b_vl[c]));
            if (c == 2) begin
                chk("l1 st rdata", b_resp_rdata, 32'h0);
                chk("l1 st err", 32'(b_resp_err), 32'd0);
            end
            if (c == 5) begin
                chk("l1 ld rdata", b_resp_rdata, 32'h5A5A5A5A);
                chk("l1 ld err", 32'(b_resp_err), 32'd0);
            end
            @(posedge clk); #1;
            if (c == 2) b_req_write = 1'b0;
        end
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("l1 idle stall", 32'(b_stall_mem), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
